// File: rtl/alt_mem_ddrx_buffer_allocator_if.sv
// Allocation/release handshake between the write-data path and the
// write-data buffer free-list allocator.
interface alt_mem_ddrx_buffer_allocator_if #(
    parameter int CFG_BUFFER_ADDR_WIDTH = 6
);
    logic                             alloc_req;
    logic                             alloc_ready;
    logic [CFG_BUFFER_ADDR_WIDTH-1:0] alloc_address;
    logic                             release_valid;
    logic [CFG_BUFFER_ADDR_WIDTH-1:0] release_address;
    logic [CFG_BUFFER_ADDR_WIDTH:0]   free_count;
    logic                             init_done;
    logic                             err_release_unused;
    logic                             err_release_in_init;

    // Requester side: asks for addresses and returns them.
    modport master (
        output alloc_req, release_valid, release_address,
        input  alloc_ready, alloc_address, free_count, init_done,
               err_release_unused, err_release_in_init
    );

    // Allocator side.
    modport slave (
        input  alloc_req, release_valid, release_address,
        output alloc_ready, alloc_address, free_count, init_done,
               err_release_unused, err_release_in_init
    );
endinterface

// File: rtl/alt_mem_ddrx_buffer_allocator.sv
// Free-list allocator for the write-data buffer. After reset the free-list
// FIFO is filled with every address 0..DEPTH-1, then addresses are handed
// out show-ahead, one per handshake, and returned addresses are queued
// behind the ones already free. An in_use bitmap rejects releases of
// addresses that are not currently allocated, which also guarantees the
// free list can never overflow.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_INIT | writing init_cnt into the free list, one address per cycle
// ST_RUN  | serving allocations and releases; left only by reset
module alt_mem_ddrx_buffer_allocator #(
    parameter int CFG_BUFFER_ADDR_WIDTH = 6
) (
    input  logic                             ctl_clk,
    input  logic                             ctl_reset_n,
    alt_mem_ddrx_buffer_allocator_if.slave   bus
);
    localparam int AW    = CFG_BUFFER_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [AW:0]   PTR_ONE  = 1;

    logic [0:0]    state;
    logic [AW-1:0] init_cnt;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   free_count;
    logic [AW-1:0] fifo [DEPTH];
    logic [DEPTH-1:0] in_use;
    logic          err_unused;
    logic          err_in_init;

    logic          run;
    logic          ptr_empty;
    logic          alloc_ready_i;
    logic [AW-1:0] alloc_addr_i;
    logic          alloc_fire;
    logic          rel_ok;
    logic          fifo_we;
    logic [AW-1:0] fifo_wdata;

    assign run       = (state == ST_RUN);
    // Pointer equality (including the wrap bit) means empty; it agrees with
    // free_count == 0 and is kept as a second, pointer-based guard.
    assign ptr_empty = (rd_ptr == wr_ptr);

    // Ready depends on registered state only, so no combinational path from
    // alloc_req or release_valid; a release into an empty list shows up
    // one cycle later.
    assign alloc_ready_i = run & (free_count != '0) & ~ptr_empty;
    assign alloc_addr_i  = fifo[rd_ptr[AW-1:0]];
    assign alloc_fire    = bus.alloc_req & alloc_ready_i;

    // Only addresses that are currently allocated may go back on the list.
    assign rel_ok     = run & bus.release_valid & in_use[bus.release_address];
    assign fifo_we    = ~run | rel_ok;
    assign fifo_wdata = run ? bus.release_address : init_cnt;

    // INIT walks init_cnt over every address once, then stays in RUN.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (!run) begin
            init_cnt <= init_cnt + ADDR_ONE;
            if (init_cnt == ADDR_MAX) begin
                state <= ST_RUN;
            end
        end
    end

    // Free-list pointers and occupancy; a simultaneous push and pop leaves
    // free_count unchanged.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            free_count <= '0;
        end else begin
            if (fifo_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (alloc_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({fifo_we, alloc_fire})
                2'b10:   free_count <= free_count + PTR_ONE;
                2'b01:   free_count <= free_count - PTR_ONE;
                default: free_count <= free_count;
            endcase
        end
    end

    // Free-list storage; cleared on reset so alloc_address reads 0 until
    // the first INIT write lands.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else if (fifo_we) begin
            fifo[wr_ptr[AW-1:0]] <= fifo_wdata;
        end
    end

    // Ownership map; the release clear is written last so it wins when both
    // name the same address.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            in_use <= '0;
        end else begin
            if (alloc_fire) begin
                in_use[alloc_addr_i] <= 1'b1;
            end
            if (rel_ok) begin
                in_use[bus.release_address] <= 1'b0;
            end
        end
    end

    // Sticky error flags for illegal releases.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            err_unused  <= 1'b0;
            err_in_init <= 1'b0;
        end else if (bus.release_valid) begin
            if (!run) begin
                err_in_init <= 1'b1;
            end else if (!in_use[bus.release_address]) begin
                err_unused <= 1'b1;
            end
        end
    end

    assign bus.alloc_ready         = alloc_ready_i;
    assign bus.alloc_address       = alloc_addr_i;
    assign bus.free_count          = free_count;
    assign bus.init_done           = run;
    assign bus.err_release_unused  = err_unused;
    assign bus.err_release_in_init = err_in_init;
endmodule

// File: tb/tb_alt_mem_ddrx_buffer_allocator.sv
// Bench for the write-data buffer allocator: a queue-based free-list model
// predicts every output each cycle; hand tables and sequences cover the
// init, exhaust, refill, simultaneous, error and reset-mid-run cases, then
// random traffic runs against the model.
module tb_alt_mem_ddrx_buffer_allocator;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    alt_mem_ddrx_buffer_allocator_if #(.CFG_BUFFER_ADDR_WIDTH(AW)) bus ();

    alt_mem_ddrx_buffer_allocator #(.CFG_BUFFER_ADDR_WIDTH(AW)) dut (
        .ctl_clk     (clk),
        .ctl_reset_n (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of free addresses plus ownership flags.
    int fq[$];
    bit m_in_use [DEPTH];
    bit m_run;
    int m_init_cnt;
    bit m_err_unused;
    bit m_err_init;

    typedef struct {
        bit req;
        bit rv;
        int ra;
        int e_addr;
        int e_fc;
        bit e_err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        for (int i = 0; i < DEPTH; i++) m_in_use[i] = 1'b0;
        m_run        = 1'b0;
        m_init_cnt   = 0;
        m_err_unused = 1'b0;
        m_err_init   = 1'b0;
    endtask

    // Called at a falling edge: drive inputs, compare against the model,
    // advance the model across the next rising edge.
    task automatic step(input bit req, input bit rv, input int ra);
        bit m_ready;
        bit do_alloc;
        bit rel_ok;
        int a;
        bus.alloc_req       = req;
        bus.release_valid   = rv;
        bus.release_address = ra[AW-1:0];
        #1;
        m_ready = m_run && (fq.size() != 0);
        chk("alloc_ready", int'(bus.alloc_ready), int'(m_ready));
        if (m_ready) chk("alloc_address", int'(bus.alloc_address), fq[0]);
        chk("free_count", int'(bus.free_count), fq.size());
        chk("init_done", int'(bus.init_done), int'(m_run));
        chk("err_release_unused", int'(bus.err_release_unused), int'(m_err_unused));
        chk("err_release_in_init", int'(bus.err_release_in_init), int'(m_err_init));
        do_alloc = req && m_ready;
        rel_ok   = rv && m_run && m_in_use[ra];
        if (rv && !m_run) m_err_init = 1'b1;
        if (rv && m_run && !m_in_use[ra]) m_err_unused = 1'b1;
        if (!m_run) begin
            fq.push_back(m_init_cnt);
            m_init_cnt++;
            if (m_init_cnt == DEPTH) m_run = 1'b1;
        end
        if (do_alloc) begin
            a = fq.pop_front();
            m_in_use[a] = 1'b1;
        end
        if (rel_ok) begin
            fq.push_back(ra);
            m_in_use[ra] = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear with no clock edge.
    task automatic do_reset();
        bus.alloc_req       = 1'b0;
        bus.release_valid   = 1'b0;
        bus.release_address = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_alloc_ready", int'(bus.alloc_ready), 0);
        chk("rst_alloc_address", int'(bus.alloc_address), 0);
        chk("rst_free_count", int'(bus.free_count), 0);
        chk("rst_init_done", int'(bus.init_done), 0);
        chk("rst_err_unused", int'(bus.err_release_unused), 0);
        chk("rst_err_in_init", int'(bus.err_release_in_init), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs INIT to completion with a bounded edge count; optionally releases
    // an address at one init cycle.
    task automatic do_init(input int rel_at);
        int n;
        n = 0;
        while (!bus.init_done && n < 200) begin
            step(1'b0, n == rel_at, 3);
            n++;
        end
        chk("init_edges", n, DEPTH);
        chk("init_free_count", int'(bus.free_count), DEPTH);
        chk("init_alloc_ready", int'(bus.alloc_ready), 1);
        chk("init_alloc_address", int'(bus.alloc_address), 0);
    endtask

    initial begin
        int cand[$];
        int ra;
        bit req;
        bit rv;

        // After init: free list 0..63; v2 releases never-allocated 5,
        // v3 returns 0, v4 allocates 2 while returning 1.
        tbl[0] = '{req: 1'b1, rv: 1'b0, ra: 0, e_addr: 0, e_fc: 64, e_err: 1'b0};
        tbl[1] = '{req: 1'b1, rv: 1'b0, ra: 0, e_addr: 1, e_fc: 63, e_err: 1'b0};
        tbl[2] = '{req: 1'b0, rv: 1'b1, ra: 5, e_addr: 2, e_fc: 62, e_err: 1'b0};
        tbl[3] = '{req: 1'b0, rv: 1'b1, ra: 0, e_addr: 2, e_fc: 62, e_err: 1'b1};
        tbl[4] = '{req: 1'b1, rv: 1'b1, ra: 1, e_addr: 2, e_fc: 63, e_err: 1'b1};
        tbl[5] = '{req: 1'b0, rv: 1'b0, ra: 0, e_addr: 3, e_fc: 63, e_err: 1'b1};

        rst_n = 1'b0;
        bus.alloc_req       = 1'b0;
        bus.release_valid   = 1'b0;
        bus.release_address = '0;
        @(negedge clk);
        do_reset();
        do_init(-1);

        for (int i = 0; i < 6; i++) begin
            bus.alloc_req = tbl[i].req;
            #1;
            chk("tbl_alloc_ready", int'(bus.alloc_ready), 1);
            chk("tbl_alloc_address", int'(bus.alloc_address), tbl[i].e_addr);
            chk("tbl_free_count", int'(bus.free_count), tbl[i].e_fc);
            chk("tbl_err_unused", int'(bus.err_release_unused), int'(tbl[i].e_err));
            step(tbl[i].req, tbl[i].rv, tbl[i].ra);
        end

        // Release during INIT: flagged and dropped, init still completes.
        do_reset();
        do_init(10);
        chk("err_in_init_set", int'(bus.err_release_in_init), 1);

        // Reset mid-run after 20 allocations, then re-init.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 0);
        do_reset();
        do_init(-1);

        // Exhaust: grants 0..63 in order, one per cycle.
        for (int i = 0; i < DEPTH; i++) begin
            chk("exhaust_addr", int'(bus.alloc_address), i);
            step(1'b1, 1'b0, 0);
        end
        chk("empty_ready", int'(bus.alloc_ready), 0);
        chk("empty_free_count", int'(bus.free_count), 0);

        // Refill from empty: no bypass in the release cycle.
        step(1'b1, 1'b1, 17);
        chk("refill_ready", int'(bus.alloc_ready), 1);
        chk("refill_free_count", int'(bus.free_count), 1);
        chk("refill_addr", int'(bus.alloc_address), 17);
        step(1'b1, 1'b0, 0);
        chk("refill_drained", int'(bus.free_count), 0);

        // Simultaneous alloc + release at free_count=10.
        for (int i = 20; i < 30; i++) step(1'b0, 1'b1, i);
        chk("sim_pre_free_count", int'(bus.free_count), 10);
        step(1'b1, 1'b1, 40);
        chk("sim_free_count", int'(bus.free_count), 10);
        for (int i = 21; i < 30; i++) begin
            chk("sim_order_addr", int'(bus.alloc_address), i);
            step(1'b1, 1'b0, 0);
        end
        chk("sim_released_addr", int'(bus.alloc_address), 40);
        step(1'b1, 1'b0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            req = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 2) != 0);
            cand.delete();
            for (int i = 0; i < DEPTH; i++) if (m_in_use[i]) cand.push_back(i);
            if (cand.size() != 0 && $urandom_range(0, 9) != 0)
                ra = cand[$urandom_range(0, cand.size() - 1)];
            else
                ra = $urandom_range(0, DEPTH - 1);
            step(req, rv, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alt_mem_ddrx_buffer_allocator.md
# alt_mem_ddrx_buffer_allocator

Free-list allocator for the write-data buffer in the DDRx controller. It hands out unused buffer addresses, one per data beat, to the write-data path that feeds the buffer manager. It reclaims each address when the read side releases that location. It also tracks per-location ownership so illegal releases are caught, not silently corrupting the free list.

## Interface
Parameters:
- CFG_BUFFER_ADDR_WIDTH, 6, buffer address width; DEPTH = 2^CFG_BUFFER_ADDR_WIDTH locations

Ports:
- ctl_clk  in  1  controller clock; all state changes on the rising edge
- ctl_reset_n  in  1  reset: ctl_reset_n, asynchronous, active-low; clock ctl_clk
- alloc_req  in  1  requester wants one buffer address this cycle
- alloc_ready  out  1  a free address is available; an allocation occurs when alloc_req & alloc_ready
- alloc_address  out  CFG_BUFFER_ADDR_WIDTH  address granted; valid whenever alloc_ready=1
- release_valid  in  1  return one address to the free list
- release_address  in  CFG_BUFFER_ADDR_WIDTH  address being returned
- free_count  out  CFG_BUFFER_ADDR_WIDTH+1  number of free addresses (0..DEPTH), registered
- init_done  out  1  free list initialised; allocator in RUN
- err_release_unused  out  1  sticky; set by a release of an address not currently allocated
- err_release_in_init  out  1  sticky; set by release_valid during INIT

## Operation
- Storage:
  - Free-list FIFO of DEPTH entries × CFG_BUFFER_ADDR_WIDTH bits.
  - Read and write pointers, each CFG_BUFFER_ADDR_WIDTH+1 bits; they wrap modulo 2·DEPTH, and the MSB distinguishes full from empty.
  - in_use bitmap of DEPTH bits.
- State machine: two states, INIT and RUN.
  - Reset enters INIT with init counter 0.
  - INIT: each cycle writes the init counter value into the FIFO at the write pointer, increments the write pointer and free_count, then increments the init counter.
  - After the cycle that writes address DEPTH-1, the next state is RUN. There is no exit from RUN except reset.
- alloc_ready = (state==RUN) & (free_count != 0). It is derived only from registered state, so it has no combinational path from alloc_req or release_valid.
- alloc_address = FIFO entry at the read pointer (show-ahead, combinational read of the register file).
- Allocation (alloc_req & alloc_ready): read pointer +1, in_use[alloc_address] set, free_count −1.
- Release in RUN with in_use[release_address]=1:
  - write release_address at the write pointer, then write pointer +1;
  - clear in_use[release_address];
  - free_count +1.
- Release in RUN with in_use[release_address]=0: dropped, no state change, err_release_unused set.
- Release during INIT: dropped, err_release_in_init set.
- Simultaneous allocation and valid release: both pointers advance, free_count unchanged.
  - If the release and allocation name the same address, the in_use clear from the release wins. This is legal only when the address was already in use before the cycle; the allocated address is always distinct from any in-use address.
- No bypass: with free_count=0, a release in cycle N does not make alloc_ready high until cycle N+1.
- Returned addresses are reissued in FIFO order, behind every address already free.
- An overflowed free list (free_count would exceed DEPTH) cannot occur, because in_use gating prevents it.

## Timing
- Reset values:
  - alloc_ready 0, alloc_address 0, free_count 0, init_done 0;
  - err_release_unused 0, err_release_in_init 0;
  - pointers 0, in_use all 0, state INIT.
- Initialisation latency: DEPTH rising edges after reset deassertion. Then init_done=1, alloc_ready=1, free_count=DEPTH, alloc_address=0.
- During INIT, free_count increments by 1 per cycle.
- Allocation throughput: one address per cycle. The next alloc_address is presented in the cycle after the handshake.
- Release-to-free_count latency: 1 cycle (registered).
- Error flags assert on the clock edge after the offending release, and stay high until reset.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), and INIT restarts on deassertion. Outstanding allocations are forgotten.

## Test plan
- Init: deassert reset with DEPTH=64 -> init_done and alloc_ready rise at edge 64, free_count=64, alloc_address=0.
- Exhaust: hold alloc_req for 64 cycles -> addresses 0..63 granted in order, one per cycle; alloc_ready=0 and free_count=0 after the 64th grant.
- Refill from empty: at free_count=0, release 17 -> free_count=1 and alloc_ready=1 the next cycle; the next grant is 17.
- Simultaneous: with free_count=10, allocate and release a valid address in the same cycle -> free_count stays 10; the released address is granted after the 10 earlier free entries.
- Errors: release 5 while never allocated -> err_release_unused=1, free_count unchanged. Release during INIT -> err_release_in_init=1, and init still completes with free_count=64.
- Reset mid-run: after 20 allocations, pulse ctl_reset_n low -> all outputs return to 0 asynchronously, and re-init grants 0..63 again.
